// File: rtl/tinker_fetch_queue.sv
// Fetch front end for the 2-wide Tinker core: owns the fetch PC, reads two words per
// cycle from memory and buffers {instruction, PC} pairs for the decode stage.
module tinker_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [63:0]              mem_pc,
  input  logic [31:0]              mem_instr0,
  input  logic [31:0]              mem_instr1,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  input  logic                     halt_fetch,
  input  logic [1:0]               deq_count,
  output logic                     out_valid0,
  output logic [31:0]              out_instr0,
  output logic [63:0]              out_pc0,
  output logic                     out_valid1,
  output logic [31:0]              out_instr1,
  output logic [63:0]              out_pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [63:0]   pc_q    [DEPTH];

  logic [1:0]    deq_req, deq_eff, enq_n;
  logic          fetch_odd;
  logic          wr_en0, wr_en1;
  logic [31:0]   wr_instr0;
  logic [63:0]   wr_pc1;
  logic [AW-1:0] wr_idx1, rd_idx1;

  assign wr_idx1 = wr_ptr_q + AW'(1);
  assign rd_idx1 = rd_ptr_q + AW'(1);
  assign fetch_odd = fetch_pc_q[2];

  // NOTE: every signal written here gets a default first so no path leaves a latch.
  always_comb begin
    deq_req    = (deq_count == 2'd3) ? 2'd2 : deq_count;
    deq_eff    = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;
    enq_n      = 2'd0;
    fetch_pc_d = fetch_pc_q;
    wr_instr0  = fetch_odd ? mem_instr1 : mem_instr0;
    wr_pc1     = fetch_pc_q + 64'd4;

    // Space is judged on the occupancy before this cycle's dequeue.
    if (!halt_fetch) begin
      if (!fetch_odd && count_q <= CW'(DEPTH - 2)) begin
        enq_n      = 2'd2;
        fetch_pc_d = fetch_pc_q + 64'd8;
      end else if (fetch_odd && count_q <= CW'(DEPTH - 1)) begin
        enq_n      = 2'd1;
        fetch_pc_d = {fetch_pc_q[63:3] + 61'd1, 3'b000};
      end
    end

    rd_ptr_d = rd_ptr_q + AW'(deq_eff);
    wr_ptr_d = wr_ptr_q + AW'(enq_n);
    count_d  = count_q - CW'(deq_eff) + CW'(enq_n);
    wr_en0   = (enq_n != 2'd0);
    wr_en1   = (enq_n == 2'd2);

    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      wr_en0     = 1'b0;
      wr_en1     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is reset on purpose so the head fields read as zero right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en0 && wr_ptr_q == AW'(i)) begin
          instr_q[i] <= wr_instr0;
          pc_q[i]    <= fetch_pc_q;
        end else if (wr_en1 && wr_idx1 == AW'(i)) begin
          instr_q[i] <= mem_instr1;
          pc_q[i]    <= wr_pc1;
        end
      end
    end
  end

  assign mem_pc     = {fetch_pc_q[63:3], 3'b000};
  assign count      = count_q;
  assign out_valid0 = (count_q >= CW'(1));
  assign out_valid1 = (count_q >= CW'(2));
  assign out_instr0 = instr_q[rd_ptr_q];
  assign out_pc0    = pc_q[rd_ptr_q];
  assign out_instr1 = instr_q[rd_idx1];
  assign out_pc1    = pc_q[rd_idx1];

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Randomized bench for tinker_fetch_queue against a queue-based reference model,
// with directed fill, redirect, halt, over-request and asynchronous reset scenarios.
module tb_tinker_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   mem_pc;
  logic [31:0]   mem_instr0, mem_instr1;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic          halt_fetch;
  logic [1:0]    deq_count;
  logic          out_valid0, out_valid1;
  logic [31:0]   out_instr0, out_instr1;
  logic [63:0]   out_pc0, out_pc1;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t      model_q[$];
  logic [63:0] model_fpc;

  tinker_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h2000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_pc      (mem_pc),
    .mem_instr0  (mem_instr0),
    .mem_instr1  (mem_instr1),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_fetch  (halt_fetch),
    .deq_count   (deq_count),
    .out_valid0  (out_valid0),
    .out_instr0  (out_instr0),
    .out_pc0     (out_pc0),
    .out_valid1  (out_valid1),
    .out_instr1  (out_instr1),
    .out_pc1     (out_pc1),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  always_comb begin
    mem_instr0 = mem_word(mem_pc);
    mem_instr1 = mem_word(mem_pc + 64'd4);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_fpc = 64'h2000;
  endtask

  // One clock of the reference model, written straight from the queue rules.
  task automatic model_step(input logic [1:0] dq, input logic rd, input logic [63:0] rpc,
                            input logic hf);
    int n, d;
    entry_t e;
    if (rd) begin
      model_q.delete();
      model_fpc = rpc & ~64'h3;
      return;
    end
    n = model_q.size();
    d = (dq == 2'd3) ? 2 : int'(dq);
    if (d > n) d = n;
    if (!hf) begin
      if (model_fpc[2] == 1'b0 && n <= DEPTH - 2) begin
        e.pc = model_fpc;          e.instr = mem_word(e.pc); model_q.push_back(e);
        e.pc = model_fpc + 64'd4;  e.instr = mem_word(e.pc); model_q.push_back(e);
        model_fpc = model_fpc + 64'd8;
      end else if (model_fpc[2] == 1'b1 && n <= DEPTH - 1) begin
        e.pc = model_fpc;          e.instr = mem_word(e.pc); model_q.push_back(e);
        model_fpc = (model_fpc & ~64'h7) + 64'd8;
      end
    end
    for (int k = 0; k < d; k++) void'(model_q.pop_front());
  endtask

  task automatic check_state();
    int n;
    n = model_q.size();
    check("count",  64'(count),      64'(n));
    check("valid0", 64'(out_valid0), 64'(n >= 1));
    check("valid1", 64'(out_valid1), 64'(n >= 2));
    check("mem_pc", mem_pc,          model_fpc & ~64'h7);
    if (n >= 1) begin
      check("pc0",    out_pc0,           model_q[0].pc);
      check("instr0", 64'(out_instr0),   64'(model_q[0].instr));
    end
    if (n >= 2) begin
      check("pc1",    out_pc1,           model_q[1].pc);
      check("instr1", 64'(out_instr1),   64'(model_q[1].instr));
    end
  endtask

  // Called at a negedge: compare, drive, advance model, move to the next negedge.
  task automatic cycle(input logic [1:0] dq, input logic rd, input logic [63:0] rpc,
                       input logic hf);
    check_state();
    deq_count   = dq;
    redirect    = rd;
    redirect_pc = rpc;
    halt_fetch  = hf;
    model_step(dq, rd, rpc, hf);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_count"},  64'(count),      64'd0);
    check({tag, "_valid0"}, 64'(out_valid0), 64'd0);
    check({tag, "_valid1"}, 64'(out_valid1), 64'd0);
    check({tag, "_instr0"}, 64'(out_instr0), 64'd0);
    check({tag, "_instr1"}, 64'(out_instr1), 64'd0);
    check({tag, "_pc0"},    out_pc0,         64'd0);
    check({tag, "_pc1"},    out_pc1,         64'd0);
    check({tag, "_mem_pc"}, mem_pc,          64'h2000);
  endtask

  initial begin
    logic [63:0] rpc;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt_fetch  = 1'b0;
    deq_count   = 2'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_zero("rst");
    reset = 1'b0;

    // Fill with no consumption: 2 per edge until full, then fetch freezes.
    for (int i = 0; i < 6; i++) cycle(2'd0, 1'b0, '0, 1'b0);
    check("full_count",  64'(count), 64'd8);
    check("full_mem_pc", mem_pc,     64'h2020);

    // Drain to 5 under halt, then redirect to an odd word with an over-dequeue.
    for (int i = 0; i < 3; i++) cycle(2'd1, 1'b0, '0, 1'b1);
    check("pre_redir_count", 64'(count), 64'd5);
    cycle(2'd2, 1'b1, 64'h3004, 1'b0);
    check("redir_count",  64'(count),      64'd0);
    check("redir_valid0", 64'(out_valid0), 64'd0);
    check("redir_mem_pc", mem_pc,          64'h3000);
    cycle(2'd0, 1'b0, '0, 1'b0);
    check("odd_count", 64'(count), 64'd1);
    check("odd_pc0",   out_pc0,    64'h3004);
    cycle(2'd0, 1'b0, '0, 1'b0);
    check("after_odd_pc1", out_pc1, 64'h3008);
    cycle(2'd1, 1'b0, '0, 1'b0);
    check("pre_halt_count", 64'(count), 64'd4);

    // Halt with single dequeues: occupancy walks down, then fetch resumes in place.
    for (int i = 0; i < 4; i++) begin
      cycle(2'd1, 1'b0, '0, 1'b1);
      check("halt_count", 64'(count), 64'(3 - i));
    end
    cycle(2'd0, 1'b0, '0, 1'b0);
    check("resume_pc0", out_pc0, 64'h3018);

    // deq_count=3 with one entry: clipped to one.
    cycle(2'd1, 1'b0, '0, 1'b1);
    check("one_left", 64'(count), 64'd1);
    cycle(2'd3, 1'b0, '0, 1'b1);
    check("clip_count", 64'(count), 64'd0);

    // Steady double dequeue: occupancy settles at 2.
    for (int i = 0; i < 8; i++) cycle(2'd2, 1'b0, '0, 1'b0);
    check("steady2_count", 64'(count), 64'd2);

    // Redirect next to the top of the address space to exercise PC wrap.
    cycle(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'd1, 1'b0, '0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        default: rpc = {$urandom, $urandom};
      endcase
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0), rpc,
            ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of a fill.
    for (int i = 0; i < 2; i++) cycle(2'd0, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    deq_count = 2'd0;
    for (int i = 0; i < 6; i++) cycle(2'd2, 1'b0, '0, 1'b0);
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tinker_fetch_queue.md
Name: tinker_fetch_queue

Overview:
- Fetch front end of the 2-wide in-order Tinker core; sits directly upstream of the IF/ID decode stage.
- Owns the fetch PC and drives the unified memory's dual-instruction read port (combinational read of two 32-bit words at an 8-byte-aligned address).
- Buffers {instruction, PC} pairs in a circular queue and presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle.
- Decouples decode stalls and dependency splits from fetch; supports branch redirect (queue flush) and a halt freeze.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 4.
- RESET_PC, 64'h2000, fetch PC after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mem_pc  output  64  memory instruction-read address = {fetch_pc[63:3], 3'b000}
- mem_instr0  input  32  word at mem_pc (same-cycle combinational)
- mem_instr1  input  32  word at mem_pc+4
- redirect  input  1  branch resolved taken: flush and refetch
- redirect_pc  input  64  new fetch PC; bits [1:0] ignored (treated as 0)
- halt_fetch  input  1  freeze fetch_pc, no enqueue; dequeue continues
- deq_count  input  2  entries decode consumes this cycle (0/1/2; 3 treated as 2)
- out_valid0  output  1  head entry valid
- out_instr0  output  32  head instruction
- out_pc0  output  64  head PC
- out_valid1  output  1  second entry valid
- out_instr1  output  32  second instruction
- out_pc1  output  64  second PC
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0; all storage entries cleared to 0.
  - Outputs after reset: out_valid0/1=0, out_instr0/1=0, out_pc0/1=0, mem_pc=RESET_PC&~7.
  - Reset mid-operation discards all entries, including any partial fetch.
- Outputs are combinational from storage at rd_ptr and rd_ptr+1 (mod DEPTH).
  - out_valid0 = (count>=1); out_valid1 = (count>=2).
  - Instruction/PC fields of an invalid slot are don't-care, except after reset (see above).
- Dequeue: deq_eff = min(deq_count clamped to 2, count). rd_ptr advances by deq_eff; over-request is silently clipped.
- Enqueue decision uses pre-dequeue count:
  - Aligned fetch_pc (fetch_pc[2]=0): need 2 slots. If count<=DEPTH-2, write {mem_instr0, fetch_pc} then {mem_instr1, fetch_pc+4}, in that order; fetch_pc += 8.
  - Odd-word fetch_pc (fetch_pc[2]=1, after redirect): need 1 slot. If count<=DEPTH-1, write only {mem_instr1, fetch_pc}; fetch_pc = {fetch_pc[63:3]+1, 3'b000}.
  - Otherwise (insufficient space): no write, fetch_pc holds.
- Enqueue and dequeue may occur in the same cycle: count_next = count - deq_eff + enq_n. Pointers wrap modulo DEPTH.
- halt_fetch=1: enq_n=0, fetch_pc holds; dequeue unaffected.
- redirect=1 (priority over everything except reset):
  - rd_ptr=wr_ptr=0 and count=0 next cycle; fetch_pc=redirect_pc & ~3.
  - deq_count and enqueue are ignored that cycle.
  - First new entries appear at the earliest on the cycle after the redirect edge, with out_valid0=0 for exactly that one cycle.
- redirect together with halt_fetch: flush and load fetch_pc, but no fetch until halt_fetch drops.
- Arithmetic: 64-bit PC adds wrap modulo 2^64 with no error.
- Latency: instruction at fetch_pc is visible on out_*0 one cycle after the enqueue edge when the queue was empty.

Test Plan:
- Reset, no stalls, deq_count=0: edge1 fills 0x2000/0x2004, edge2 fills 0x2008/0x200C, …; count reaches 8 after 4 edges, then holds at 8 with mem_pc=0x2020 frozen.
- Steady deq_count=2 from the first valid cycle: out_pc0/out_pc1 sequence 0x2000/0x2004, 0x2008/0x200C, …; count stays 2, never exceeds 2.
- Alternate deq_count=1/2: FIFO order is preserved (out_pc0 strictly +4 per consumed entry); count climbs and saturates at DEPTH-1 or DEPTH, never overflows.
- With count=5, redirect=1, redirect_pc=0x3004, deq_count=2: next cycle count=0, out_valid0=0, mem_pc=0x3000; following edge enqueues only 0x3004 (count=1), then 0x3008/0x300C.
- halt_fetch=1 with count=4, deq_count=1 for 4 cycles: count goes 3, 2, 1, 0 with no new enqueues; after halt_fetch drops, fetch resumes at the held fetch_pc.
- deq_count=3 with count=1: treated as 2 and clipped to 1, so count=0 (plus any enqueue), with no pointer corruption; then assert reset mid-fill: all outputs are 0 immediately (asynchronous).
